// File: rtl/vscale_dmem_adapter_pkg.sv
// Shared constants and types for the vscale data-memory adapter and its checker.
package vscale_dmem_adapter_pkg;

  localparam int MEM_TYPE_WIDTH = 3;

  localparam logic [MEM_TYPE_WIDTH-1:0] DMEM_SIZE_B = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] DMEM_SIZE_H = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] DMEM_SIZE_W = 3'd2;

  // Response timeout counter width; TIMEOUT must not exceed 2**width - 1.
  localparam int DMEM_TIMEOUT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FAULT = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/vscale_dmem_check.sv
// Combinational access checker: alignment, size legality, address window and
// byte-lane write mask. Shared between the data and (future) instruction adapters.
module vscale_dmem_check
  import vscale_dmem_adapter_pkg::*;
#(
  parameter int                 XPR_LEN   = 32,
  parameter logic [XPR_LEN-1:0] ADDR_BASE = '0,
  parameter logic [XPR_LEN-1:0] ADDR_SIZE = 32'h0001_0000
) (
  input  logic [XPR_LEN-1:0]        addr,
  input  logic [MEM_TYPE_WIDTH-1:0] size,
  input  logic                      wen,
  output logic                      fault,
  output logic [3:0]                wmask
);

  logic               size_bad;
  logic               misaligned;
  logic               in_range;
  logic [3:0]         lane_mask;
  logic [XPR_LEN-1:0] offset;

  // Decode size into lane mask and alignment fault; window test avoids overflow
  // by comparing the offset from the base rather than base+size.
  always_comb begin
    size_bad   = 1'b0;
    misaligned = 1'b0;
    lane_mask  = 4'b0000;
    case (size)
      DMEM_SIZE_B: lane_mask = 4'b0001 << addr[1:0];
      DMEM_SIZE_H: begin
        misaligned = addr[0];
        lane_mask  = 4'b0011 << addr[1:0];
      end
      DMEM_SIZE_W: begin
        misaligned = |addr[1:0];
        lane_mask  = 4'b1111;
      end
      default: size_bad = 1'b1;
    endcase
    offset   = addr - ADDR_BASE;
    in_range = (addr >= ADDR_BASE) && (offset < ADDR_SIZE);
    fault    = size_bad | misaligned | ~in_range;
    wmask    = wen ? lane_mask : 4'b0000;
  end

endmodule

// File: rtl/vscale_dmem_adapter.sv
// Bridges the vscale split-phase data-memory port (addr/ctrl in DX, store data
// and load result in WB) onto a single-outstanding valid/ready request bus.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing pending
//   ST_FAULT | captured access faulted; report badmem for one cycle, no bus
//   ST_ISSUE | request on the bus, waiting for ready; WB stalled
//   ST_RESP  | request accepted, waiting for response or timeout
module vscale_dmem_adapter
  import vscale_dmem_adapter_pkg::*;
#(
  parameter int                 XPR_LEN   = 32,
  parameter logic [XPR_LEN-1:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [XPR_LEN-1:0] ADDR_SIZE = 32'h0001_0000,
  parameter int                 TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [XPR_LEN-1:0]        dmem_addr,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic                      dmem_wait,
  output logic [XPR_LEN-1:0]        dmem_rdata,
  output logic                      dmem_badmem_e,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic                      bus_req_wen,
  output logic [XPR_LEN-1:0]        bus_req_addr,
  output logic [3:0]                bus_req_wmask,
  output logic [XPR_LEN-1:0]        bus_req_wdata,
  input  logic                      bus_resp_valid,
  input  logic [XPR_LEN-1:0]        bus_resp_rdata,
  input  logic                      bus_resp_err
);

  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [DMEM_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = DMEM_TIMEOUT_WIDTH'(TIMEOUT - 1);

  dmem_state_t                   state, state_nxt;
  logic                          req_wen_q;
  logic [XPR_LEN-1:0]            req_addr_q;
  logic [3:0]                    req_wmask_q;
  logic [DMEM_TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [XPR_LEN-1:0]            rdata_q;

  logic       chk_fault;
  logic [3:0] chk_wmask;
  logic       timeout_hit;
  logic       resp_done;
  logic       capture;

  vscale_dmem_check #(
    .XPR_LEN   (XPR_LEN),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_check (
    .addr  (dmem_addr),
    .size  (dmem_size),
    .wen   (dmem_wen),
    .fault (chk_fault),
    .wmask (chk_wmask)
  );

  // Timeout fires in the last allowed RESP cycle only if the slave stays silent.
  assign timeout_hit = TIMEOUT_EN && (state == ST_RESP) &&
                       (tmo_cnt == TIMEOUT_LAST) && !bus_resp_valid;

  assign bus_req_valid = (state == ST_ISSUE);
  assign bus_req_wen   = req_wen_q;
  assign bus_req_addr  = req_addr_q;
  assign bus_req_wmask = req_wmask_q;
  assign bus_req_wdata = dmem_wdata_delayed;

  // Next state, WB stall and completion outputs; a completing RESP cycle acts
  // like IDLE so a new DX access can be captured with no bubble.
  always_comb begin
    state_nxt     = state;
    resp_done     = (state == ST_RESP) && (bus_resp_valid || timeout_hit);
    dmem_wait     = (state == ST_ISSUE) ||
                    ((state == ST_RESP) && !bus_resp_valid && !timeout_hit);
    capture       = dmem_en && !dmem_wait;
    dmem_rdata    = rdata_q;
    dmem_badmem_e = 1'b0;

    case (state)
      ST_IDLE, ST_FAULT: state_nxt = ST_IDLE;
      ST_ISSUE: if (bus_req_ready) state_nxt = ST_RESP;
      ST_RESP:  if (resp_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (capture) state_nxt = chk_fault ? ST_FAULT : ST_ISSUE;

    if (state == ST_FAULT) dmem_badmem_e = 1'b1;
    if (resp_done) begin
      dmem_rdata    = timeout_hit ? '0 : bus_resp_rdata;
      dmem_badmem_e = bus_resp_err | timeout_hit;
    end
  end

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Request fields latched at capture and held for the whole bus transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wmask_q <= 4'b0000;
    end else if (capture) begin
      req_wen_q   <= dmem_wen;
      req_addr_q  <= {dmem_addr[XPR_LEN-1:2], 2'b00};
      req_wmask_q <= chk_wmask;
    end
  end

  // Response-wait counter: cleared when the request is accepted, counts RESP cycles.
  always_ff @(posedge clk) begin
    if (reset)                                    tmo_cnt <= '0;
    else if ((state == ST_ISSUE) && bus_req_ready) tmo_cnt <= '0;
    else if (state == ST_RESP)                    tmo_cnt <= tmo_cnt + DMEM_TIMEOUT_WIDTH'(1);
  end

  // Hold the last load result so WB sees a stable value outside completion.
  always_ff @(posedge clk) begin
    if (reset)          rdata_q <= '0;
    else if (resp_done) rdata_q <= dmem_rdata;
  end

endmodule

// File: tb/tb_vscale_dmem_adapter.sv
// Scoreboard bench: a pipeline model feeds DX/WB, a bus slave model answers with
// per-access delays, expected results are queued at capture and popped at completion.
module tb_vscale_dmem_adapter;

  localparam int TO   = 4;
  localparam int NONE = 255;
  localparam int NOPS = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dmem_en = 1'b0;
  logic        dmem_wen = 1'b0;
  logic [2:0]  dmem_size = 3'd0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata_delayed = 32'h0;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        dmem_badmem_e;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_req_wen;
  logic [31:0] bus_req_addr;
  logic [3:0]  bus_req_wmask;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_resp_rdata = 32'h0;
  logic        bus_resp_err = 1'b0;

  vscale_dmem_adapter #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_wait          (dmem_wait),
    .dmem_rdata         (dmem_rdata),
    .dmem_badmem_e      (dmem_badmem_e),
    .bus_req_valid      (bus_req_valid),
    .bus_req_ready      (bus_req_ready),
    .bus_req_wen        (bus_req_wen),
    .bus_req_addr       (bus_req_addr),
    .bus_req_wmask      (bus_req_wmask),
    .bus_req_wdata      (bus_req_wdata),
    .bus_resp_valid     (bus_resp_valid),
    .bus_resp_rdata     (bus_resp_rdata),
    .bus_resp_err       (bus_resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rd;
    int          resp;
    logic [31:0] rdata;
    logic        err;
    int          gap;
    bit          stray;
  } op_t;

  typedef struct {
    logic [31:0] rd;
    logic        bad;
    int          stall;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  op_t  ops [NOPS];
  exp_t sbq [$];
  req_t reqq [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_fault_f(input op_t o);
    logic [31:0] a;
    bit f;
    a = o.addr;
    f = 1'b0;
    if (o.size > 3'd2) f = 1'b1;
    if (o.size == 3'd1 && a[0]) f = 1'b1;
    if (o.size == 3'd2 && a[1:0] != 2'b00) f = 1'b1;
    if (a >= 32'h0001_0000) f = 1'b1;
    return f;
  endfunction

  function automatic logic [3:0] exp_wmask_f(input op_t o);
    logic [31:0] a;
    a = o.addr;
    if (!o.wen) return 4'b0000;
    case (o.size)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return 4'b0011 << a[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  initial begin
    int next_idx, gap_cnt, wb_idx, stall, req_cnt, resp_cnt, cyc;
    bit wb_valid, in_resp, stray_now, stray_next, issue_next;
    bit complete, handshake, capture, flt;
    logic [31:0] last_rd;
    exp_t e;
    req_t r;

    //          wen   size  addr           wdata          rd  resp  rdata          err   gap stray
    ops[0]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         0,  0,    32'hDEAD_BEEF, 1'b0, 0,  0};
    ops[1]  = '{1'b1, 3'd0, 32'h0000_0103, 32'h5A5A_5A5A, 3,  1,    32'h0,         1'b0, 3,  0};
    ops[2]  = '{1'b0, 3'd1, 32'h0000_0101, 32'h0,         0,  0,    32'h0,         1'b0, 2,  0};
    ops[3]  = '{1'b0, 3'd2, 32'h0002_0000, 32'h0,         0,  0,    32'h0,         1'b0, 0,  0};
    ops[4]  = '{1'b1, 3'd2, 32'h0000_0200, 32'h1122_3344, 0,  0,    32'h0,         1'b0, 0,  0};
    ops[5]  = '{1'b0, 3'd1, 32'h0000_0202, 32'h0,         1,  2,    32'hCAFE_F00D, 1'b0, 0,  0};
    ops[6]  = '{1'b1, 3'd1, 32'h0000_0306, 32'hABCD_ABCD, 0,  0,    32'h0000_0055, 1'b1, 0,  0};
    ops[7]  = '{1'b0, 3'd0, 32'h0000_0401, 32'h0,         0,  NONE, 32'h0,         1'b0, 0,  1};
    ops[8]  = '{1'b0, 3'd3, 32'h0000_0500, 32'h0,         0,  0,    32'h0,         1'b0, 10, 0};
    ops[9]  = '{1'b0, 3'd2, 32'h0000_FFFC, 32'h0,         2,  3,    32'h0BAD_F00D, 1'b0, 0,  0};
    ops[10] = '{1'b0, 3'd2, 32'h0001_0000, 32'h0,         0,  0,    32'h0,         1'b0, 0,  0};
    ops[11] = '{1'b1, 3'd0, 32'h0000_0000, 32'h7777_7777, 0,  0,    32'h1357_2468, 1'b0, 0,  0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wait",   32'(dmem_wait), 32'h0);
    chk("rst_bad",    32'(dmem_badmem_e), 32'h0);
    chk("rst_rdata",  dmem_rdata, 32'h0);
    chk("rst_valid",  32'(bus_req_valid), 32'h0);
    chk("rst_wen",    32'(bus_req_wen), 32'h0);
    chk("rst_addr",   bus_req_addr, 32'h0);
    chk("rst_wmask",  32'(bus_req_wmask), 32'h0);
    reset = 1'b0;

    next_idx = 0; gap_cnt = 0; wb_idx = 0; stall = 0; req_cnt = 0; resp_cnt = 0; cyc = 0;
    wb_valid = 0; in_resp = 0; stray_next = 0; issue_next = 0;
    last_rd = 32'h0;

    while (!(next_idx == NOPS && !wb_valid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
      stray_now  = stray_next;
      stray_next = 0;

      bus_req_ready  = bus_req_valid && wb_valid && (req_cnt == ops[wb_idx].rd);
      bus_resp_valid = 1'b0;
      bus_resp_rdata = 32'h0;
      bus_resp_err   = 1'b0;
      if (wb_valid && in_resp && resp_cnt == ops[wb_idx].resp) begin
        bus_resp_valid = 1'b1;
        bus_resp_rdata = ops[wb_idx].rdata;
        bus_resp_err   = ops[wb_idx].err;
      end
      if (stray_now) begin
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'hBAD0_0BAD;
        bus_resp_err   = 1'b1;
      end

      dmem_en   = (next_idx < NOPS) && (gap_cnt == 0);
      dmem_wen  = 1'b0;
      dmem_size = 3'd0;
      dmem_addr = 32'h0;
      if (dmem_en) begin
        dmem_wen  = ops[next_idx].wen;
        dmem_size = ops[next_idx].size;
        dmem_addr = ops[next_idx].addr;
      end
      dmem_wdata_delayed = wb_valid ? ops[wb_idx].wdata : 32'h0;
      #1;

      if (issue_next) chk("issue_next", 32'(bus_req_valid), 32'h1);
      issue_next = 0;

      if (stray_now) begin
        chk("stray_wait",  32'(dmem_wait), 32'h0);
        chk("stray_bad",   32'(dmem_badmem_e), 32'h0);
        chk("stray_rdata", dmem_rdata, last_rd);
      end

      if (wb_valid && exp_fault_f(ops[wb_idx]))
        chk("fault_noreq", 32'(bus_req_valid), 32'h0);

      if (bus_req_valid) begin
        if (reqq.size() == 0) begin
          chk("spurious_req", 32'(bus_req_valid), 32'h0);
        end else begin
          r = reqq[0];
          chk("req_addr",  bus_req_addr, r.addr);
          chk("req_wen",   32'(bus_req_wen), 32'(r.wen));
          chk("req_wmask", 32'(bus_req_wmask), 32'(r.wmask));
          chk("req_wdata", bus_req_wdata, r.wdata);
        end
      end

      complete = wb_valid && !dmem_wait;
      if (complete) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'(sbq.size()), 32'h1);
        end else begin
          e = sbq.pop_front();
          chk("cmp_rdata", dmem_rdata, e.rd);
          chk("cmp_bad",   32'(dmem_badmem_e), 32'(e.bad));
          chk("cmp_stall", 32'(stall), 32'(e.stall));
        end
      end
      if (wb_valid && dmem_wait) stall++;

      handshake = bus_req_valid && bus_req_ready;
      if (handshake && reqq.size() > 0) void'(reqq.pop_front());
      capture = dmem_en && !dmem_wait;

      if (bus_req_valid && !bus_req_ready) req_cnt++;
      if (in_resp && !bus_resp_valid) resp_cnt++;
      if (handshake) begin
        in_resp  = 1;
        resp_cnt = 0;
      end
      if (complete) begin
        wb_valid = 0;
        in_resp  = 0;
        if (ops[wb_idx].stray) stray_next = 1;
      end
      if (gap_cnt > 0) gap_cnt--;
      if (capture) begin
        flt = exp_fault_f(ops[next_idx]);
        if (flt) begin
          e.rd = last_rd; e.bad = 1'b1; e.stall = 0;
        end else begin
          e.rd    = (ops[next_idx].resp == NONE) ? 32'h0 : ops[next_idx].rdata;
          e.bad   = (ops[next_idx].resp == NONE) ? 1'b1 : ops[next_idx].err;
          e.stall = ops[next_idx].rd + 1 +
                    ((ops[next_idx].resp == NONE) ? (TO - 1) : ops[next_idx].resp);
          r.addr  = {ops[next_idx].addr[31:2], 2'b00};
          r.wen   = ops[next_idx].wen;
          r.wmask = exp_wmask_f(ops[next_idx]);
          r.wdata = ops[next_idx].wdata;
          reqq.push_back(r);
        end
        last_rd = e.rd;
        sbq.push_back(e);
        wb_valid   = 1;
        wb_idx     = next_idx;
        stall      = 0;
        req_cnt    = 0;
        in_resp    = 0;
        issue_next = !flt;
        next_idx++;
        if (next_idx < NOPS) gap_cnt = ops[next_idx].gap;
      end
    end

    chk("run_done", 32'(next_idx == NOPS && !wb_valid), 32'h1);
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    // Reset while a store waits in ISSUE with ready low
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = 3'd2; dmem_addr = 32'h0000_0040;
    @(negedge clk);
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = 32'h0;
    #1;
    chk("pre_rst_valid", 32'(bus_req_valid), 32'h1);
    chk("pre_rst_wait",  32'(dmem_wait), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(bus_req_valid), 32'h0);
    chk("mid_rst_wait",  32'(dmem_wait), 32'h0);
    chk("mid_rst_bad",   32'(dmem_badmem_e), 32'h0);
    chk("mid_rst_rdata", dmem_rdata, 32'h0);
    chk("mid_rst_wen",   32'(bus_req_wen), 32'h0);
    chk("mid_rst_addr",  bus_req_addr, 32'h0);
    chk("mid_rst_wmask", 32'(bus_req_wmask), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_valid", 32'(bus_req_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
